sid_waveform_mixer: RTL and testbench
=====================================

Name: sid_waveform_mixer

Overview:
Consumer end of the waveform generator output bundle (sid::waveform_i_t), one instance per voice. Combines the selected waveforms into the 12-bit waveform DAC input. Models the floating DAC hold/fade when no waveform is selected. Returns noise write-back bits to the generator's LFSR and provides the OSC3 readback value to the register file.

Parameters:
FADE_6581, 20'd54000, SID cycles a floating 6581 waveform output is held before dropping to 0.
FADE_8580, 20'd800000, same for 8580.

Ports:
clk  input  1  system clock
res  input  1  synchronous active-high reset
model  input  sid::model_e  MOS6581 / MOS8580
phase  input  sid::phase_t  SID cycle phase strobes; mixer acts on phase[sid::PHI2] only
wave_i  input  sid::waveform_i_t  selector[3:0] (noise, pulse, sawtooth, triangle), noise[7:0], pulse, saw_tri[11:0]
wave  output  12  waveform DAC value
osc3  output  8  OSC3 readback value, = wave[11:4]
noise_wb  output  8  LFSR write-back bits, ordered as wave_i.noise
noise_wb_en  output  1  write-back strobe, 1 clk wide

Behaviour:
- Reset (res high at a clk edge): wave=0, osc3=0, noise_wb=0, noise_wb_en=0, fade counter=0. res wins over any phase strobe in the same cycle.
- All state updates occur only on clk edges with phase[PHI2]=1. wave/osc3 are registered and change on the edge following a PHI2 sample (1-clk latency). No update in other phases.
- Component values:
  - tri = {saw_tri[10:0], 1'b0}
  - saw = saw_tri
  - pul = {12{pulse}}
  - noi = {noise[7:0], 4'b0}
- Selected (selector!=0): mix = bitwise AND of all selected components, so single selection passes the component through unchanged.
  - wave<=mix, osc3<=mix[11:4].
  - Fade counter <= FADE_6581 if model==MOS6581, else FADE_8580.
- Floating (selector==0):
  - wave and osc3 hold their value.
  - Fade counter decrements by 1 per PHI2, saturating at 0.
  - On the PHI2 where the counter goes 1->0, wave<=0 and osc3<=0.
  - Counter already 0: wave stays 0.
- Re-selection at any fade count: the output immediately takes the mix value and the counter reloads.
- model change while floating: counter not reloaded; takes effect on next reload.
- Noise write-back:
  - When selector[3]=1 and at least one other selector bit is set, on that PHI2 edge: noise_wb <= {mix[11:4]} and noise_wb_en <= 1 for exactly one clk, then noise_wb_en returns to 0.
  - The generator uses the strobe to AND the LFSR tap bits with noise_wb.
  - Noise alone: no strobe.
  - noise_wb holds its last value when not strobed.
- Arithmetic: no adders except the 20-bit fade counter; no wrap-around permitted (saturating).

Optional Feature:
SID_WAVE_PULLDOWN_EN
- Defined: when model==MOS6581 and both sawtooth and triangle are selected, mix[i] = mix_and[i] & mix_and[i+1] for i=0..10 and mix[11] = mix_and[11]. This approximates bit pull-down in the 6581 combined saw/tri output, and noise write-back uses this mix.
- Undefined: pure bitwise AND for all models and combinations.

Test Plan:
- Reset: assert res during PHI2 with selector=4'b0010, saw_tri=12'hFFF -> wave=0, osc3=0, noise_wb_en=0 after edge; after release, next PHI2 gives wave=12'hFFF, osc3=8'hFF.
- Single selections: saw_tri=12'hA55. Triangle -> wave=12'h4AA. Pulse=1 alone -> 12'hFFF. Noise=8'h3C alone -> 12'h3C0, no noise_wb_en.
- Combined AND: saw+pulse with saw_tri=12'h8F0, pulse=0 -> wave=0. Noise+saw with noise=8'hFF, saw_tri=12'h5A5 -> wave=12'h5A0, noise_wb=8'h5A, noise_wb_en high 1 clk.
- 6581 fade: FADE_6581=4, wave=12'h123, then selector=0 -> wave=12'h123 for PHI2 #1-3, wave=0 after PHI2 #4; osc3 tracks.
- 8580 fade/reselect: FADE_8580=3, deselect for 2 PHI2 then select saw=12'h777 -> wave=12'h777 immediately; deselect again -> holds 3 PHI2 total before 0.
- Pulldown (macro on, 6581, saw+tri): saw_tri=12'hFFF -> mix_and=12'hFFE -> wave=12'hFFC. Macro off -> wave=12'hFFE. 8580 with macro on -> 12'hFFE.

Source files
------------

// File: rtl/sid_waveform_mixer.sv
// Per-voice SID waveform mixer. It combines the selected waveforms, holds and then fades a floating DAC,
// and returns noise write-back bits. Define SID_WAVE_PULLDOWN_EN to enable the 6581 saw+tri bit pull-down.
package sid;
  typedef enum logic {
    MOS6581 = 1'b0,
    MOS8580 = 1'b1
  } model_e;

  localparam int PHI1 = 0;
  localparam int PHI2 = 1;
  typedef logic [1:0] phase_t;

  typedef struct packed {
    logic [3:0]  selector;  // {noise, pulse, sawtooth, triangle}
    logic [7:0]  noise;
    logic        pulse;
    logic [11:0] saw_tri;
  } waveform_i_t;
endpackage

module sid_waveform_mixer #(
  parameter logic [19:0] FADE_6581 = 20'd54000,
  parameter logic [19:0] FADE_8580 = 20'd800000
) (
  input  logic              clk,
  input  logic              res,
  input  sid::model_e       model,
  input  sid::phase_t       phase,
  input  sid::waveform_i_t  wave_i,
  output logic [11:0]       wave,
  output logic [7:0]        osc3,
  output logic [7:0]        noise_wb,
  output logic              noise_wb_en
);

  logic [11:0] comp_tri;
  logic [11:0] comp_saw;
  logic [11:0] comp_pul;
  logic [11:0] comp_noi;
  logic [11:0] mix_and;
  logic [11:0] mix;
  logic        phi2;
  logic        unused_phase;

  logic [11:0] wave_reg, wave_next;
  logic [19:0] fade_reg, fade_next;
  logic [7:0]  noise_wb_reg, noise_wb_next;
  logic        noise_wb_en_reg, noise_wb_en_next;

  assign phi2         = phase[sid::PHI2];
  assign unused_phase = phase[sid::PHI1];

  assign comp_tri = {wave_i.saw_tri[10:0], 1'b0};
  assign comp_saw = wave_i.saw_tri;
  assign comp_pul = {12{wave_i.pulse}};
  assign comp_noi = {wave_i.noise, 4'b0000};

  // Unselected components contribute all-ones so the AND passes the selected ones through.
  always_comb begin
    mix_and = 12'hFFF;
    if (wave_i.selector[0]) mix_and = mix_and & comp_tri;
    if (wave_i.selector[1]) mix_and = mix_and & comp_saw;
    if (wave_i.selector[2]) mix_and = mix_and & comp_pul;
    if (wave_i.selector[3]) mix_and = mix_and & comp_noi;
  end

`ifdef SID_WAVE_PULLDOWN_EN
  logic [11:0] mix_pd;

  // Each bit of the 6581 saw+tri output is pulled low by a low bit directly above it.
  generate
    for (genvar gi = 0; gi < 11; gi++) begin : g_pulldown
      assign mix_pd[gi] = mix_and[gi] & mix_and[gi+1];
    end
  endgenerate
  assign mix_pd[11] = mix_and[11];

  assign mix = ((model == sid::MOS6581) && (wave_i.selector[1:0] == 2'b11)) ? mix_pd : mix_and;
`else
  assign mix = mix_and;
`endif

  always_comb begin
    wave_next        = wave_reg;
    fade_next        = fade_reg;
    noise_wb_next    = noise_wb_reg;
    noise_wb_en_next = 1'b0;
    if (phi2) begin
      if (wave_i.selector != 4'b0000) begin
        wave_next = mix;
        fade_next = (model == sid::MOS6581) ? FADE_6581 : FADE_8580;
        if (wave_i.selector[3] && (wave_i.selector[2:0] != 3'b000)) begin
          noise_wb_next    = mix[11:4];
          noise_wb_en_next = 1'b1;
        end
      end else begin
        // Floating DAC: hold until the counter expires, saturating at zero.
        if (fade_reg != 20'd0) begin
          fade_next = fade_reg - 20'd1;
        end
        if (fade_reg <= 20'd1) begin
          wave_next = 12'h000;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wave_reg        <= 12'h000;
      fade_reg        <= 20'd0;
      noise_wb_reg    <= 8'h00;
      noise_wb_en_reg <= 1'b0;
    end else begin
      wave_reg        <= wave_next;
      fade_reg        <= fade_next;
      noise_wb_reg    <= noise_wb_next;
      noise_wb_en_reg <= noise_wb_en_next;
    end
  end

  assign wave        = wave_reg;
  assign osc3        = wave_reg[11:4];
  assign noise_wb    = noise_wb_reg;
  assign noise_wb_en = noise_wb_en_reg;

endmodule

// File: tb/tb_sid_waveform_mixer.sv
// Self-checking bench for sid_waveform_mixer: directed test-plan steps followed by randomized steps
// checked against a behavioural model (fade lengths shortened through the parameters).
module tb_sid_waveform_mixer;
  import sid::*;

  localparam logic [19:0] F6581 = 20'd4;
  localparam logic [19:0] F8580 = 20'd3;

  logic        clk = 1'b0;
  logic        res;
  model_e      model;
  phase_t      phase;
  waveform_i_t wave_i;
  logic [11:0] wave;
  logic [7:0]  osc3;
  logic [7:0]  noise_wb;
  logic        noise_wb_en;

  int tests = 0;
  int fails = 0;

  // Reference state: the DAC value, PHI2 cycles of hold remaining, and the write-back outputs.
  logic [11:0] m_wave = 12'h000;
  int          m_left = 0;
  logic [7:0]  m_wb   = 8'h00;
  logic        m_en   = 1'b0;

  sid_waveform_mixer #(
    .FADE_6581(F6581),
    .FADE_8580(F8580)
  ) dut (
    .clk        (clk),
    .res        (res),
    .model      (model),
    .phase      (phase),
    .wave_i     (wave_i),
    .wave       (wave),
    .osc3       (osc3),
    .noise_wb   (noise_wb),
    .noise_wb_en(noise_wb_en)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_mix(input waveform_i_t w);
    logic [11:0] comps [4];
    logic [11:0] acc;
    comps[0] = {w.saw_tri[10:0], 1'b0};
    comps[1] = w.saw_tri;
    comps[2] = {12{w.pulse}};
    comps[3] = {w.noise, 4'h0};
    acc = 12'hFFF;
    for (int k = 0; k < 4; k++)
      if (w.selector[k]) acc = acc & comps[k];
`ifdef SID_WAVE_PULLDOWN_EN
    if (model == MOS6581 && w.selector[1:0] == 2'b11) begin
      logic [11:0] pd;
      pd = acc;
      for (int b = 0; b < 11; b++) pd[b] = acc[b] & acc[b+1];
      acc = pd;
    end
`endif
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic p2, input model_e m, input logic [3:0] sel,
                      input logic [7:0] nz, input logic pl, input logic [11:0] st);
    logic [11:0] mx;
    res              = r;
    model            = m;
    phase            = '0;
    phase[PHI2]      = p2;
    phase[PHI1]      = !p2;
    wave_i.selector  = sel;
    wave_i.noise     = nz;
    wave_i.pulse     = pl;
    wave_i.saw_tri   = st;
    mx   = ref_mix(wave_i);
    m_en = 1'b0;
    if (r) begin
      m_wave = 12'h000;
      m_left = 0;
      m_wb   = 8'h00;
    end else if (p2) begin
      if (sel != 4'b0000) begin
        m_wave = mx;
        m_left = (m == MOS6581) ? int'(F6581) : int'(F8580);
        if (sel[3] && sel[2:0] != 3'b000) begin
          m_wb = mx[11:4];
          m_en = 1'b1;
        end
      end else begin
        m_left = (m_left > 0) ? m_left - 1 : 0;
        if (m_left == 0) m_wave = 12'h000;
      end
    end
    @(posedge clk);
    #1;
    chk("wave", wave, m_wave);
    chk("osc3", {4'h0, osc3}, {4'h0, m_wave[11:4]});
    chk("noise_wb", {4'h0, noise_wb}, {4'h0, m_wb});
    chk("noise_wb_en", {11'h0, noise_wb_en}, {11'h0, m_en});
    $display("[TB] t=%0t res=%0b phi2=%0b model=%0d sel=%b wave=%h osc3=%h wb=%h en=%0b",
             $time, r, p2, m, sel, wave, osc3, noise_wb, noise_wb_en);
  endtask

  initial begin
    res    = 1'b1;
    model  = MOS6581;
    phase  = '0;
    wave_i = '0;

    // Reset wins over a PHI2 strobe in the same cycle.
    step(1'b1, 1'b1, MOS6581, 4'b0010, 8'h00, 1'b0, 12'hFFF);
    chk("tp_reset_wave", wave, 12'h000);
    chk("tp_reset_en", {11'h0, noise_wb_en}, 12'h000);
    step(1'b0, 1'b1, MOS6581, 4'b0010, 8'h00, 1'b0, 12'hFFF);
    chk("tp_saw_fff", wave, 12'hFFF);
    chk("tp_saw_osc3", {4'h0, osc3}, 12'h0FF);

    // No update outside PHI2, then single selections.
    step(1'b0, 1'b0, MOS6581, 4'b0001, 8'h00, 1'b0, 12'hA55);
    chk("tp_no_phi2", wave, 12'hFFF);
    step(1'b0, 1'b1, MOS6581, 4'b0001, 8'h00, 1'b0, 12'hA55);
    chk("tp_tri", wave, 12'h4AA);
    step(1'b0, 1'b1, MOS6581, 4'b0100, 8'h00, 1'b1, 12'hA55);
    chk("tp_pulse", wave, 12'hFFF);
    step(1'b0, 1'b1, MOS6581, 4'b1000, 8'h3C, 1'b0, 12'hA55);
    chk("tp_noise", wave, 12'h3C0);
    chk("tp_noise_no_en", {11'h0, noise_wb_en}, 12'h000);

    // Combined selections and noise write-back strobe.
    step(1'b0, 1'b1, MOS6581, 4'b0110, 8'h00, 1'b0, 12'h8F0);
    chk("tp_saw_pulse", wave, 12'h000);
    step(1'b0, 1'b1, MOS6581, 4'b1010, 8'hFF, 1'b0, 12'h5A5);
    chk("tp_noise_saw", wave, 12'h5A0);
    chk("tp_wb", {4'h0, noise_wb}, 12'h05A);
    chk("tp_wb_en", {11'h0, noise_wb_en}, 12'h001);
    step(1'b0, 1'b0, MOS6581, 4'b1010, 8'hFF, 1'b0, 12'h5A5);
    chk("tp_wb_en_drop", {11'h0, noise_wb_en}, 12'h000);

    // 6581 fade: held for three PHI2 cycles, zero on the fourth.
    step(1'b0, 1'b1, MOS6581, 4'b0010, 8'h00, 1'b0, 12'h123);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b1, MOS6581, 4'b0000, 8'h00, 1'b0, 12'h000);
      step(1'b0, 1'b0, MOS6581, 4'b0000, 8'h00, 1'b0, 12'h000);
      chk("tp_fade6581", wave, (i < 4) ? 12'h123 : 12'h000);
    end

    // 8580 fade interrupted by reselection.
    step(1'b0, 1'b1, MOS8580, 4'b0010, 8'h00, 1'b0, 12'h321);
    step(1'b0, 1'b1, MOS8580, 4'b0000, 8'h00, 1'b0, 12'h000);
    step(1'b0, 1'b1, MOS8580, 4'b0000, 8'h00, 1'b0, 12'h000);
    step(1'b0, 1'b1, MOS8580, 4'b0010, 8'h00, 1'b0, 12'h777);
    chk("tp_reselect", wave, 12'h777);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b1, MOS8580, 4'b0000, 8'h00, 1'b0, 12'h000);
      chk("tp_fade8580", wave, (i < 3) ? 12'h777 : 12'h000);
    end

    // Saw+tri combination for each model.
    step(1'b0, 1'b1, MOS8580, 4'b0011, 8'h00, 1'b0, 12'hFFF);
    chk("tp_sawtri_8580", wave, 12'hFFE);
    step(1'b0, 1'b1, MOS6581, 4'b0011, 8'h00, 1'b0, 12'hFFF);
    chk("tp_sawtri_6581", wave, ref_mix(wave_i));

    // Randomized steps, with frequent deselection so fades and reselections occur.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] sel;
      sel = ($urandom_range(0, 9) < 4) ? 4'b0000 : 4'($urandom);
      step(($urandom_range(0, 59) == 0), 1'($urandom), model_e'($urandom_range(0, 1)), sel,
           8'($urandom), 1'($urandom), 12'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
